// File: rtl/ahb_cmd_sequencer.sv
// ahb_cmd_sequencer: buffers AHB transaction descriptors and write words, then replays
// them onto the master's ext_*/start_trans/stop_trans request interface with fixed phasing.
// Ports: hclk/hresetn (sync, active-low); cmd_* descriptor stream (valid/ready);
// wd_* write-data stream (valid/ready); start_trans/stop_trans/ext_* master request;
// busy (work pending), cmd_err (descriptor dropped).
// Optional: define AHB_SEQ_STATS_EN to add txn_count (completed transactions, 16-bit wrap).
module ahb_cmd_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int WDATA_DEPTH = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [4:0]            cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  start_trans,
  output logic                  stop_trans,
  output logic [ADDR_WIDTH-1:0] ext_haddr,
  output logic                  ext_hwrite,
  output logic [2:0]            ext_hburst,
  output logic [2:0]            ext_hsize,
  output logic [DATA_WIDTH-1:0] ext_hwdata,
  output logic                  busy,
  output logic                  cmd_err
`ifdef AHB_SEQ_STATS_EN
  ,
  output logic [15:0]           txn_count
`endif
);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int WA = $clog2(WDATA_DEPTH);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  // Beat count and legality are resolved at push so the IDLE launch check is a plain compare.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            burst;
    logic [2:0]            size;
    logic [4:0]            nb;
    logic                  bad;
  } cmd_t;
  cmd_t cmd_mem [CMD_DEPTH];
  cmd_t cmd_in, head;
  logic [CA-1:0] cmd_wp, cmd_rp;
  logic [CA:0] cmd_cnt, cmd_cnt_nxt;
  logic cmd_push, cmd_pop;
  logic [DATA_WIDTH-1:0] wd_mem [WDATA_DEPTH];
  logic [WA-1:0] wd_wp, wd_rp;
  logic [WA:0] wd_cnt;
  logic wd_push, wd_pop;
  logic [2:0] state, nxt;
  logic [4:0] nbeats, beat;
  logic launch, drop, last_beat;
  assign cmd_ready = cmd_cnt != (CA + 1)'(CMD_DEPTH);
  assign wd_ready = wd_cnt != (WA + 1)'(WDATA_DEPTH);
  assign cmd_push = cmd_valid && cmd_ready;
  assign wd_push = wd_valid && wd_ready;
  assign head = cmd_mem[cmd_rp];
  always_comb begin
    cmd_in.addr = cmd_addr;
    cmd_in.write = cmd_write;
    cmd_in.burst = cmd_burst;
    cmd_in.size = cmd_size;
    cmd_in.nb = cmd_burst == 3'd0 ? 5'd1 :
                cmd_burst == 3'd1 ? (cmd_len == 5'd0 ? 5'd1 : cmd_len > 5'd16 ? 5'd16 : cmd_len) :
                cmd_burst[2:1] == 2'b01 ? 5'd4 :
                cmd_burst[2:1] == 2'b10 ? 5'd8 : 5'd16;
    cmd_in.bad = int'(cmd_size) > MAX_SIZE;
    // Illegal heads are discarded without waiting for write data.
    drop = state == S_IDLE && cmd_cnt != '0 && head.bad;
    launch = state == S_IDLE && cmd_cnt != '0 && !head.bad &&
             (!head.write || int'(wd_cnt) >= int'(head.nb));
    cmd_pop = launch || drop;
    cmd_cnt_nxt = cmd_cnt + (CA + 1)'(cmd_push) - (CA + 1)'(cmd_pop);
    last_beat = beat == nbeats - 5'd1;
    // A word is fetched on the edge entering each DATA cycle, so beat i shows at ADDR+1+i.
    wd_pop = ext_hwrite && (state == S_ADDR || (state == S_DATA && !last_beat));
    nxt = state == S_IDLE ? (launch ? S_ADDR : S_IDLE) :
          state == S_ADDR ? S_DATA :
          state == S_DATA ? (last_beat ? S_STOP : S_DATA) :
          state == S_STOP ? S_GAP : S_IDLE;
  end
  always_ff @(posedge hclk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= cmd_in;
    if (wd_push) wd_mem[wd_wp] <= wd_data;
  end
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cmd_wp <= '0;
      cmd_rp <= '0;
      cmd_cnt <= '0;
      wd_wp <= '0;
      wd_rp <= '0;
      wd_cnt <= '0;
      nbeats <= '0;
      beat <= '0;
      start_trans <= 1'b0;
      stop_trans <= 1'b0;
      busy <= 1'b0;
      cmd_err <= 1'b0;
      ext_haddr <= '0;
      ext_hwrite <= 1'b0;
      ext_hburst <= '0;
      ext_hsize <= '0;
      ext_hwdata <= '0;
    end else begin
      state <= nxt;
      start_trans <= nxt == S_ADDR || nxt == S_DATA;
      stop_trans <= nxt == S_STOP;
      busy <= nxt != S_IDLE || cmd_cnt_nxt != '0;
      cmd_err <= drop;
      beat <= state == S_DATA ? beat + 5'd1 : 5'd0;
      cmd_cnt <= cmd_cnt_nxt;
      wd_cnt <= wd_cnt + (WA + 1)'(wd_push) - (WA + 1)'(wd_pop);
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop) cmd_rp <= cmd_rp + 1'b1;
      if (wd_push) wd_wp <= wd_wp + 1'b1;
      if (wd_pop) wd_rp <= wd_rp + 1'b1;
      if (wd_pop) ext_hwdata <= wd_mem[wd_rp];
      if (launch) begin
        ext_haddr <= head.addr;
        ext_hwrite <= head.write;
        ext_hburst <= head.burst;
        ext_hsize <= head.size;
        nbeats <= head.nb;
      end
    end
  end
`ifdef AHB_SEQ_STATS_EN
  always_ff @(posedge hclk) begin
    if (!hresetn) txn_count <= '0;
    else if (state == S_STOP) txn_count <= txn_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb_ahb_cmd_sequencer: directed and randomized checks of ahb_cmd_sequencer against a transaction-level model.
module tb_ahb_cmd_sequencer;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_burst = '0;
  logic [2:0]  cmd_size = '0;
  logic [4:0]  cmd_len = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic        start_trans, stop_trans, ext_hwrite, busy, cmd_err;
  logic [31:0] ext_haddr, ext_hwdata;
  logic [2:0]  ext_hburst, ext_hsize;
`ifdef AHB_SEQ_STATS_EN
  logic [15:0] txn_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];
  logic [31:0] last_wd = '0;
  int txns = 0;

  ahb_cmd_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .WDATA_DEPTH(16)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .start_trans(start_trans), .stop_trans(stop_trans), .ext_haddr(ext_haddr),
    .ext_hwrite(ext_hwrite), .ext_hburst(ext_hburst), .ext_hsize(ext_hsize),
    .ext_hwdata(ext_hwdata), .busy(busy), .cmd_err(cmd_err)
`ifdef AHB_SEQ_STATS_EN
    , .txn_count(txn_count)
`endif
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input logic [2:0] b, input logic [4:0] len);
    case (b)
      3'd0: return 1;
      3'd1: return len == 5'd0 ? 1 : (len > 5'd16 ? 16 : int'(len));
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic push_cmd(input logic [31:0] a, input logic w, input logic [2:0] b,
                          input logic [2:0] s, input logic [4:0] l);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_write = w;
    cmd_burst = b;
    cmd_size = s;
    cmd_len = l;
    while (!cmd_ready && t < 100) begin tick(); t++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_wd(input logic [31:0] d);
    int t = 0;
    wd_valid = 1'b1;
    wd_data = d;
    while (!wd_ready && t < 100) begin tick(); t++; end
    chk("wd_ready_wait", 64'(wd_ready), 64'd1);
    tick();
    wd_valid = 1'b0;
    wq.push_back(d);
  endtask

  task automatic observe(input string tag, input logic [31:0] a, input logic w, input logic [2:0] b,
                         input logic [2:0] s, input int n, input int exp_wait);
    int t = 0;
    while (!start_trans && t < 60) begin tick(); t++; end
    chk({tag, ":rise"}, 64'(start_trans), 64'd1);
    if (exp_wait >= 0) chk({tag, ":latency"}, 64'(t), 64'(exp_wait));
    chk({tag, ":haddr"}, 64'(ext_haddr), 64'(a));
    chk({tag, ":hwrite"}, 64'(ext_hwrite), 64'(w));
    chk({tag, ":hburst"}, 64'(ext_hburst), 64'(b));
    chk({tag, ":hsize"}, 64'(ext_hsize), 64'(s));
    chk({tag, ":stop_in_addr"}, 64'(stop_trans), 64'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ":start_in_data"}, 64'(start_trans), 64'd1);
      chk({tag, ":stop_in_data"}, 64'(stop_trans), 64'd0);
      if (w && wq.size() > 0) last_wd = wq.pop_front();
      chk({tag, ":hwdata"}, 64'(ext_hwdata), 64'(last_wd));
    end
    tick();
    chk({tag, ":start_in_stop"}, 64'(start_trans), 64'd0);
    chk({tag, ":stop_pulse"}, 64'(stop_trans), 64'd1);
    tick();
    chk({tag, ":start_in_gap"}, 64'(start_trans), 64'd0);
    chk({tag, ":stop_in_gap"}, 64'(stop_trans), 64'd0);
    txns++;
`ifdef AHB_SEQ_STATS_EN
    chk({tag, ":txn_count"}, 64'(txn_count), 64'(txns & 16'hFFFF));
`endif
  endtask

  initial begin
    int t;
    tick();
    tick();
    chk("rst:start", 64'(start_trans), 64'd0);
    chk("rst:stop", 64'(stop_trans), 64'd0);
    chk("rst:haddr", 64'(ext_haddr), 64'd0);
    chk("rst:hwdata", 64'(ext_hwdata), 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:cmd_err", 64'(cmd_err), 64'd0);
    chk("rst:cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst:wd_ready", 64'(wd_ready), 64'd1);
    hresetn = 1'b1;
    tick();

    push_wd(32'd11);
    push_wd(32'd12);
    push_wd(32'd13);
    push_wd(32'd52);
    push_cmd(32'h4000001E, 1'b1, 3'd3, 3'd2, 5'd0);
    observe("incr4_wr", 32'h4000001E, 1'b1, 3'd3, 3'd2, 4, 1);
    tick();
    chk("incr4_wr:idle_busy", 64'(busy), 64'd0);

    push_cmd(32'hC000004E, 1'b1, 3'd0, 3'd2, 5'd0);
    tick();
    tick();
    tick();
    chk("gated:no_start", 64'(start_trans), 64'd0);
    chk("gated:busy", 64'(busy), 64'd1);
    push_wd(32'd10);
    observe("gated", 32'hC000004E, 1'b1, 3'd0, 3'd2, 1, 1);

    push_wd(32'd14);
    push_cmd(32'h4000001E, 1'b0, 3'd3, 3'd2, 5'd0);
    fork
      push_cmd(32'h8000005E, 1'b1, 3'd0, 3'd2, 5'd0);
      observe("rd_incr4", 32'h4000001E, 1'b0, 3'd3, 3'd2, 4, 1);
    join
    observe("b2b_wr", 32'h8000005E, 1'b1, 3'd0, 3'd2, 1, 2);
    tick();
    chk("b2b:busy_drop", 64'(busy), 64'd0);

    push_cmd(32'h00001000, 1'b1, 3'd0, 3'd2, 5'd0);
    push_cmd(32'h00002000, 1'b0, 3'd0, 3'd1, 5'd0);
    push_cmd(32'h00003000, 1'b0, 3'd0, 3'd3, 5'd0);
    push_cmd(32'h00004000, 1'b0, 3'd1, 3'd0, 5'd2);
    chk("full:cmd_ready", 64'(cmd_ready), 64'd0);
    push_wd(32'h55);
    chk("full:still_full", 64'(cmd_ready), 64'd0);
    observe("full_wr", 32'h00001000, 1'b1, 3'd0, 3'd2, 1, 1);
    chk("full:ready_back", 64'(cmd_ready), 64'd1);
    observe("full_rd1", 32'h00002000, 1'b0, 3'd0, 3'd1, 1, 2);
    tick();
    chk("drop:no_err_yet", 64'(cmd_err), 64'd0);
    tick();
    chk("drop:cmd_err", 64'(cmd_err), 64'd1);
    chk("drop:no_start", 64'(start_trans), 64'd0);
    observe("full_rd2", 32'h00004000, 1'b0, 3'd1, 3'd0, 2, 1);
    chk("drop:err_cleared", 64'(cmd_err), 64'd0);

    for (int i = 0; i < 8; i++) push_wd(32'hA0 + 32'(i));
    push_cmd(32'h00005000, 1'b1, 3'd5, 3'd2, 5'd0);
    t = 0;
    while (!start_trans && t < 60) begin tick(); t++; end
    chk("rst_mid:rise", 64'(start_trans), 64'd1);
    tick();
    tick();
    tick();
    chk("rst_mid:beat3", 64'(ext_hwdata), 64'hA2);
    hresetn = 1'b0;
    tick();
    chk("rst_mid:start", 64'(start_trans), 64'd0);
    chk("rst_mid:stop", 64'(stop_trans), 64'd0);
    chk("rst_mid:haddr", 64'(ext_haddr), 64'd0);
    chk("rst_mid:hwrite", 64'(ext_hwrite), 64'd0);
    chk("rst_mid:hburst", 64'(ext_hburst), 64'd0);
    chk("rst_mid:hsize", 64'(ext_hsize), 64'd0);
    chk("rst_mid:hwdata", 64'(ext_hwdata), 64'd0);
    chk("rst_mid:busy", 64'(busy), 64'd0);
`ifdef AHB_SEQ_STATS_EN
    chk("rst_mid:txn_count", 64'(txn_count), 64'd0);
`endif
    hresetn = 1'b1;
    wq.delete();
    last_wd = '0;
    txns = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid:no_stop", 64'(stop_trans), 64'd0);
    end
    push_cmd(32'h00006000, 1'b1, 3'd0, 3'd2, 5'd0);
    tick();
    tick();
    chk("rst_mid:wd_empty", 64'(start_trans), 64'd0);
    push_wd(32'hAB);
    observe("post_rst", 32'h00006000, 1'b1, 3'd0, 3'd2, 1, 1);

    push_wd(32'h77);
    push_cmd(32'h00007000, 1'b1, 3'd1, 3'd2, 5'd0);
    observe("incr_len0", 32'h00007000, 1'b1, 3'd1, 3'd2, 1, 1);
    push_cmd(32'h00008000, 1'b0, 3'd1, 3'd2, 5'd20);
    observe("incr_len20", 32'h00008000, 1'b0, 3'd1, 3'd2, 16, 1);

    for (int r = 0; r < 16; r++) begin
      logic [31:0] a;
      logic w;
      logic [2:0] b, s;
      logic [4:0] l;
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      b = 3'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 3));
      l = 5'($urandom_range(0, 31));
      if (s == 3'd3) begin
        push_cmd(a, w, b, s, l);
        tick();
        chk("rnd:drop_err", 64'(cmd_err), 64'd1);
        chk("rnd:drop_start", 64'(start_trans), 64'd0);
        tick();
        chk("rnd:drop_err_off", 64'(cmd_err), 64'd0);
      end else begin
        if (w) for (int k = 0; k < beats(b, l); k++) push_wd($urandom);
        push_cmd(a, w, b, s, l);
        observe("rnd", a, w, b, s, beats(b, l), 1);
      end
    end
    tick();
    chk("end:busy", 64'(busy), 64'd0);
    chk("end:cmd_ready", 64'(cmd_ready), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
